// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state encoding and default frame geometry for the serial display chain
package p2s_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV = 2;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    SETUP = ST_SETUP,
    HIGH = ST_HIGH,
    LATCH = ST_LATCH,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every DIV clk cycles, restarted by clear
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int DW = $clog2(DIV + 1);
  logic [DW-1:0] cnt;
  assign tick = cnt == DW'(DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || clear || tick) cnt <= '0;
    else cnt <= cnt + DW'(1);
endmodule

// File: rtl/p2s_shift_tx.sv
// p2s_shift_tx: shifts a parallel word out to the serial display chain, then pulses its latch enable
module p2s_shift_tx
  import p2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV = DEF_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdat,
  output logic             sen
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic tick, clear;
  tick_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );
  assign clear = state_n != state;
  always_comb begin
    state_n = state;
    shadow_n = shadow;
    bit_cnt_n = bit_cnt;
    unique case (state)
      IDLE: if (start) begin
        state_n = SETUP;
        shadow_n = data;
        bit_cnt_n = CW'(WIDTH - 1);
      end
      SETUP: state_n = tick ? HIGH : SETUP;
      HIGH: if (tick) begin
        if (bit_cnt == '0) state_n = LATCH;
        else begin
          state_n = SETUP;
          shadow_n = MSB_FIRST ? shadow << 1 : shadow >> 1;
          bit_cnt_n = bit_cnt - CW'(1);
        end
      end
      LATCH: state_n = tick ? DONE : LATCH;
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they leave the flops glitch-free
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      bit_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sclk <= 1'b0;
      sdat <= 1'b0;
      sen <= 1'b0;
    end else begin
      state <= state_n;
      shadow <= shadow_n;
      bit_cnt <= bit_cnt_n;
      busy <= state_n == SETUP || state_n == HIGH || state_n == LATCH;
      done <= state_n == DONE;
      sclk <= state_n == HIGH;
      sdat <= (state_n == SETUP || state_n == HIGH) && (MSB_FIRST ? shadow_n[WIDTH-1] : shadow_n[0]);
      sen <= state_n == LATCH;
    end
endmodule

// File: tb/tb_p2s_shift_tx.sv
// tb_p2s_shift_tx: three transmitter configurations checked against a frame-timing model and a chain receiver
module tb_p2s_shift_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] data16 = '0;
  logic [7:0] data8 = '0;
  logic [2:0] busy, done, sclk, sdat, sen;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int phase = 0;
  int phase_seen = 0;
  int t0 = 0;
  int b_done0 = 0, b_done2 = 0, b_sen0 = 0;
  logic [15:0] w3 = '0;
  int mk[3] = '{0, 0, 0};
  logic [15:0] mw[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] rx[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] seq[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] store[3] = '{16'h0, 16'h0, 16'h0};
  int n_sen[3] = '{0, 0, 0};
  int n_done[3] = '{0, 0, 0};
  int done_cyc[3] = '{0, 0, 0};
  int sen_cyc[3] = '{0, 0, 0};
  int busy_cyc[3] = '{0, 0, 0};
  logic [2:0] sclk_q = '0, sen_q = '0, done_q = '0, busy_q = '0;
  logic [4:0] g_v, e_v;

  always #5 clk = ~clk;

  p2s_shift_tx #(.WIDTH(16), .DIV(2), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data16),
    .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .sdat(sdat[0]), .sen(sen[0]));
  p2s_shift_tx #(.WIDTH(16), .DIV(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data16),
    .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .sdat(sdat[1]), .sen(sen[1]));
  p2s_shift_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data8),
    .busy(busy[2]), .done(done[2]), .sclk(sclk[2]), .sdat(sdat[2]), .sen(sen[2]));

  function automatic int ws(int i);
    return i == 2 ? 8 : 16;
  endfunction
  function automatic int ds(int i);
    return i == 2 ? 1 : 2;
  endfunction
  function automatic bit ms(int i);
    return i != 1;
  endfunction

  // frame offset k (1 = cycle after start) -> {busy, done, sclk, sdat, sen}
  function automatic logic [4:0] expect_out(int k, logic [15:0] w, int wd, int d, bit msb);
    int p, ph;
    if (k < 1) return 5'b0;
    if (k <= 2 * d * wd) begin
      p = (k - 1) / (2 * d);
      ph = (k - 1) % (2 * d);
      return {1'b1, 1'b0, ph >= d, w[msb ? wd - 1 - p : p], 1'b0};
    end
    if (k <= 2 * d * wd + d) return 5'b10001;
    if (k == 2 * d * wd + d + 1) return 5'b01000;
    return 5'b0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) mk[i] = 0;
      else if (mk[i] != 0) mk[i] = (mk[i] == 2 * ds(i) * ws(i) + ds(i) + 1) ? 0 : mk[i] + 1;
      else if (start) begin
        mk[i] = 1;
        mw[i] = i == 2 ? {8'h0, data8} : data16;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      e_v = expect_out(mk[i], mw[i], ws(i), ds(i), ms(i));
      g_v = {busy[i], done[i], sclk[i], sdat[i], sen[i]};
      check($sformatf("outputs_dut%0d", i), 32'(g_v), 32'(e_v));
      if (sclk[i] && !sclk_q[i]) begin
        seq[i] = {seq[i][14:0], sdat[i]};
        rx[i] = ms(i) ? (((rx[i] << 1) | 16'(sdat[i])) & 16'((32'd1 << ws(i)) - 1))
                      : ((rx[i] >> 1) | (16'(sdat[i]) << (ws(i) - 1)));
      end
      if (sen[i] && !sen_q[i]) begin
        store[i] = rx[i];
        n_sen[i]++;
        sen_cyc[i] = cyc;
        check($sformatf("rx_word_dut%0d", i), 32'(store[i]), 32'(mw[i]));
      end
      if (done[i] && !done_q[i]) begin
        n_done[i]++;
        done_cyc[i] = cyc;
      end
      if (busy[i] && !busy_q[i]) busy_cyc[i] = cyc;
    end
    sclk_q = sclk;
    sen_q = sen;
    done_q = done;
    busy_q = busy;
    if (phase != phase_seen) begin
      case (phase)
        1: begin
          check("basic_done_count", 32'(n_done[0] - b_done0), 32'd1);
          check("basic_done_cycle", 32'(done_cyc[0] - t0), 32'd67);
          check("basic_sen_cycle", 32'(sen_cyc[0] - t0), 32'd65);
          check("basic_busy_rise", 32'(busy_cyc[0] - t0), 32'd1);
          check("basic_bits", 32'(seq[0]), 32'h0000A5C3);
          check("basic_rx", 32'(store[0]), 32'h0000A5C3);
          check("lsb_bits", 32'(seq[1]), 32'h0000C3A5);
          check("lsb_rx", 32'(store[1]), 32'h0000A5C3);
          check("div1_done_cycle", 32'(done_cyc[2] - t0), 32'd18);
          check("div1_done_count", 32'(n_done[2] - b_done2), 32'd1);
          check("div1_bits", 32'(seq[2][7:0]), 32'h81);
        end
        2: begin
          check("b2b_busy_rise", 32'(busy_cyc[0] - t0), 32'd69);
          check("b2b_sen_count", 32'(n_sen[0] - b_sen0), 32'd2);
          check("b2b_bits", 32'(seq[0]), 32'h000000FF);
          check("b2b_rx", 32'(store[0]), 32'h000000FF);
          check("b2b_lsb_rx", 32'(store[1]), 32'h000000FF);
        end
        3: begin
          check("rst_outputs", 32'({busy, done, sclk, sdat, sen}), 32'd0);
          check("rst_no_sen", 32'(n_sen[0] - b_sen0), 32'd0);
          check("rst_rx_kept", 32'(store[0]), 32'h000000FF);
        end
        4: begin
          check("after_rst_rx", 32'(store[0]), 32'(w3));
          check("after_rst_lsb_rx", 32'(store[1]), 32'(w3));
          check("after_rst_done_count", 32'(n_done[0] - b_done0), 32'd1);
          check("after_rst_done_cycle", 32'(done_cyc[0] - t0), 32'd89);
        end
        default: ;
      endcase
      phase_seen = phase;
    end
  end

  task automatic to_cycle(input int c);
    while (cyc != t0 + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
    b_done0 = n_done[0];
    b_done2 = n_done[2];
    start = 1'b1;
    data16 = 16'hA5C3;
    data8 = 8'h81;
    to_cycle(1);
    start = 1'b0;
    to_cycle(5);
    data16 = 16'h0000;
    data8 = 8'h00;
    to_cycle(10);
    start = 1'b1;
    to_cycle(11);
    start = 1'b0;
    to_cycle(75);
    phase = 1;
    to_cycle(77);
    t0 = cyc;
    b_sen0 = n_sen[0];
    start = 1'b1;
    data16 = 16'h00FF;
    data8 = 8'($urandom);
    to_cycle(70);
    start = 1'b0;
    to_cycle(140);
    phase = 2;
    to_cycle(142);
    t0 = cyc;
    b_sen0 = n_sen[0];
    b_done0 = n_done[0];
    start = 1'b1;
    data16 = 16'h3C5A;
    data8 = 8'($urandom);
    to_cycle(1);
    start = 1'b0;
    to_cycle(20);
    rst_n = 1'b0;
    to_cycle(21);
    rst_n = 1'b1;
    phase = 3;
    to_cycle(22);
    w3 = 16'($urandom);
    start = 1'b1;
    data16 = w3;
    to_cycle(23);
    start = 1'b0;
    to_cycle(92);
    phase = 4;
    repeat (3000) begin
      @(posedge clk);
      #1;
      start = ($urandom % 6) == 0;
      data16 = 16'($urandom);
      data8 = 8'($urandom);
      rst_n = ($urandom % 150) != 0;
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
